// File: rtl/counter_ctrl_if.sv
// rtl/counter_ctrl_if.sv - command valid/ready handshake bundle for counter_ctrl
interface counter_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;

   modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - command sequencer for the up/down counter datapath
// Prescaled step enable, one-cycle parallel load, one-shot terminal stop and free-run wrap.
module counter_ctrl #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 4
) (
   input  logic             clk,
   input  logic             rst,
   counter_ctrl_if.slave    cmd,
   input  logic             cfg_oneshot,
   input  logic             cfg_up,
   input  logic [WIDTH-1:0] cnt_val,
   output logic             cnt_en,
   output logic             cnt_up,
   output logic             cnt_load,
   output logic [WIDTH-1:0] cnt_load_val,
   output logic             busy,
   output logic             done,
   output logic             wrap
);
   localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

   localparam logic [1:0] OP_START = 2'b00;
   localparam logic [1:0] OP_STOP  = 2'b01;
   localparam logic [1:0] OP_LOAD  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_LOAD, S_DONE} state_t;

   state_t           state_q, state_d;
   state_t           ret_q, ret_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic             up_q, up_d;
   logic             os_q, os_d;
   logic             load_q, load_d;
   logic [WIDTH-1:0] lval_q, lval_d;
   logic             done_q, done_d;
   logic             wrap_q, wrap_d;
   logic             accept, tick, term;

   assign cmd.cmd_ready = ~rst & (state_q != S_LOAD);
   assign accept        = cmd.cmd_valid & cmd.cmd_ready;
   assign tick          = (state_q == S_RUN) && (presc_q == PMAX);
   assign term          = up_q ? (cnt_val == {WIDTH{1'b1}}) : (cnt_val == '0);

   assign cnt_en       = tick & ~(os_q & term);
   assign cnt_up       = up_q;
   assign cnt_load     = load_q;
   assign cnt_load_val = lval_q;
   assign busy         = (state_q == S_RUN) || (state_q == S_LOAD);
   assign done         = done_q;
   assign wrap         = wrap_q;

   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      presc_d = presc_q;
      up_d    = up_q;
      os_d    = os_q;
      load_d  = 1'b0;
      lval_d  = lval_q;
      done_d  = 1'b0;
      wrap_d  = 1'b0;

      case (state_q)
         S_RUN: begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick && term) begin
               if (os_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  wrap_d = 1'b1;
               end
            end
         end
         S_LOAD: begin
            // Prescaler phase survives a load only when returning to RUN.
            state_d = ret_q;
            if (ret_q != S_RUN) presc_d = '0;
         end
         default: presc_d = '0;
      endcase

      if (accept) begin
         unique case (cmd.cmd_op)
            OP_START: begin
               if (state_q != S_RUN) begin
                  state_d = S_RUN;
                  up_d    = cfg_up;
                  os_d    = cfg_oneshot;
                  presc_d = '0;
               end
            end
            OP_STOP: begin
               state_d = S_IDLE;
               done_d  = 1'b0;
               wrap_d  = 1'b0;
            end
            OP_LOAD: begin
               state_d = S_LOAD;
               ret_d   = (state_q == S_RUN) ? S_RUN : S_IDLE;
               load_d  = 1'b1;
               lval_d  = cmd.cmd_data;
               done_d  = 1'b0;
               wrap_d  = 1'b0;
            end
            OP_CLEAR: begin
               state_d = S_LOAD;
               ret_d   = S_IDLE;
               load_d  = 1'b1;
               lval_d  = '0;
               done_d  = 1'b0;
               wrap_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ret_q   <= S_IDLE;
         presc_q <= '0;
         up_q    <= 1'b1;
         os_q    <= 1'b0;
         load_q  <= 1'b0;
         lval_q  <= '0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         presc_q <= presc_d;
         up_q    <= up_d;
         os_q    <= os_d;
         load_q  <= load_d;
         lval_q  <= lval_d;
         done_q  <= done_d;
         wrap_q  <= wrap_d;
      end
   end
endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - bench for counter_ctrl with behavioural counter and reference model
module tb_counter_ctrl;
   localparam int W = 4;
   localparam int P = 4;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_LOAD = 2;
   localparam int M_DONE = 3;

   localparam logic [1:0] C_START = 2'b00;
   localparam logic [1:0] C_STOP  = 2'b01;
   localparam logic [1:0] C_LOAD  = 2'b10;
   localparam logic [1:0] C_CLEAR = 2'b11;

   logic         clk = 1'b0;
   logic         rst;
   logic         cnt_rst;
   logic         cfg_oneshot, cfg_up;
   logic [W-1:0] cnt_val;
   logic         cnt_en, cnt_up, cnt_load, busy, done, wrap;
   logic [W-1:0] cnt_load_val;
   logic [W-1:0] cnt_q;

   int tests = 0;
   int fails = 0;

   int           m_mode, m_after, m_phase;
   bit           m_up, m_os, m_done, m_wrap;
   logic [W-1:0] m_cnt, m_lval;
   bit           saw_done, saw_wrap;

   always #5 clk = ~clk;

   counter_ctrl_if #(.WIDTH(W)) cif ();

   counter_ctrl #(.WIDTH(W), .PRESCALE(P)) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd          (cif),
      .cfg_oneshot  (cfg_oneshot),
      .cfg_up       (cfg_up),
      .cnt_val      (cnt_val),
      .cnt_en       (cnt_en),
      .cnt_up       (cnt_up),
      .cnt_load     (cnt_load),
      .cnt_load_val (cnt_load_val),
      .busy         (busy),
      .done         (done),
      .wrap         (wrap)
   );

   // Counter register: parallel load wins over step enable.
   always @(posedge clk) begin
      if (cnt_rst)       cnt_q <= '0;
      else if (cnt_load) cnt_q <= cnt_load_val;
      else if (cnt_en)   cnt_q <= cnt_up ? cnt_q + 4'd1 : cnt_q - 4'd1;
   end
   assign cnt_val = cnt_q;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_after = M_IDLE; m_phase = 0;
      m_up = 1'b1; m_os = 1'b0; m_done = 1'b0; m_wrap = 1'b0; m_lval = '0;
   endtask

   // One clock: check outputs at the falling edge, then advance the model by the spec rules.
   task automatic cyc();
      bit e_ready, e_tick, e_term, e_en, e_load, e_busy, acc, nd, nw;
      @(negedge clk);
      e_ready = !rst && (m_mode != M_LOAD);
      e_tick  = (m_mode == M_RUN) && (m_phase == P - 1);
      e_term  = m_up ? (m_cnt == 4'hF) : (m_cnt == 4'h0);
      e_en    = e_tick && !(m_os && e_term);
      e_load  = (m_mode == M_LOAD);
      e_busy  = (m_mode == M_RUN) || (m_mode == M_LOAD);
      chk("cmd_ready", 32'(cif.cmd_ready), 32'(e_ready));
      chk("cnt_en",    32'(cnt_en),        32'(e_en));
      chk("cnt_load",  32'(cnt_load),      32'(e_load));
      chk("cnt_up",    32'(cnt_up),        32'(m_up));
      chk("busy",      32'(busy),          32'(e_busy));
      chk("done",      32'(done),          32'(m_done));
      chk("wrap",      32'(wrap),          32'(m_wrap));
      chk("cnt_val",   32'(cnt_val),       32'(m_cnt));
      chk("load_en_excl", 32'(cnt_load & cnt_en), 32'd0);
      if (e_load) chk("cnt_load_val", 32'(cnt_load_val), 32'(m_lval));
      saw_done |= (done === 1'b1);
      saw_wrap |= (wrap === 1'b1);

      if (cnt_rst)     m_cnt = '0;
      else if (e_load) m_cnt = m_lval;
      else if (e_en)   m_cnt = m_up ? m_cnt + 4'd1 : m_cnt - 4'd1;

      acc = cif.cmd_valid && e_ready;
      nd = 1'b0; nw = 1'b0;
      if (rst) begin
         model_reset();
      end else begin
         if (m_mode == M_RUN) begin
            m_phase = (m_phase + 1) % P;
            if (e_tick && e_term) begin
               if (m_os) begin m_mode = M_DONE; nd = 1'b1; end
               else nw = 1'b1;
            end
         end else if (m_mode == M_LOAD) begin
            m_mode = m_after;
            if (m_after != M_RUN) m_phase = 0;
         end
         if (acc) begin
            case (cif.cmd_op)
               C_START: if (e_busy == 1'b0) begin
                  m_mode = M_RUN; m_up = cfg_up; m_os = cfg_oneshot; m_phase = 0;
               end
               C_STOP: begin m_mode = M_IDLE; nd = 1'b0; nw = 1'b0; end
               default: begin
                  m_after = (cif.cmd_op == C_LOAD && e_busy) ? M_RUN : M_IDLE;
                  m_lval  = (cif.cmd_op == C_LOAD) ? cif.cmd_data : '0;
                  m_mode  = M_LOAD; nd = 1'b0; nw = 1'b0;
               end
            endcase
         end
         m_done = nd; m_wrap = nw;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cmd(input logic [1:0] op, input logic [W-1:0] data);
      cif.cmd_valid = 1'b1; cif.cmd_op = op; cif.cmd_data = data;
      cyc();
      cif.cmd_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cnt_rst = 1'b1;
      cif.cmd_valid = 1'b0; cif.cmd_op = 2'b00; cif.cmd_data = '0;
      cfg_oneshot = 1'b0; cfg_up = 1'b1;
      saw_done = 1'b0; saw_wrap = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      m_cnt = '0;
      cyc();
      rst = 1'b0; cnt_rst = 1'b0;
      cyc();
      chk("reset_ready", 32'(cif.cmd_ready), 32'd1);
      chk("reset_busy",  32'(busy), 32'd0);

      // Free-run up through 15 -> 0.
      cmd(C_CLEAR, 4'h9);
      cyc();
      cfg_oneshot = 1'b0; cfg_up = 1'b1;
      cmd(C_START, '0);
      saw_wrap = 1'b0;
      for (int i = 0; i < 100 && !saw_wrap; i++) cyc();
      chk("fr_wrap_seen", 32'(saw_wrap), 32'd1);
      chk("fr_wrap_val",  32'(cnt_val), 32'd0);
      cmd(C_STOP, '0);
      cyc();

      // One-shot down from 3.
      cmd(C_LOAD, 4'd3);
      cyc();
      cfg_oneshot = 1'b1; cfg_up = 1'b0;
      cmd(C_START, '0);
      saw_done = 1'b0;
      for (int i = 0; i < 40 && !saw_done; i++) cyc();
      chk("os_done_seen", 32'(saw_done), 32'd1);
      chk("os_final_val", 32'(cnt_val), 32'd0);
      chk("os_done_busy", 32'(busy), 32'd0);
      cyc();
      cmd(C_STOP, '0);

      // LOAD while running.
      cmd(C_LOAD, 4'd0);
      cyc();
      cfg_oneshot = 1'b0; cfg_up = 1'b1;
      cmd(C_START, '0);
      for (int i = 0; i < 60 && cnt_val != 4'd5; i++) cyc();
      chk("run_reach5", 32'(cnt_val), 32'd5);
      cmd(C_LOAD, 4'd12);
      chk("run_load_strobe", 32'(cnt_load), 32'd1);
      cyc();
      chk("run_load_val", 32'(cnt_val), 32'd12);
      chk("run_busy", 32'(busy), 32'd1);
      repeat (8) cyc();
      chk("run_resumed", 32'(cnt_val), 32'd14);
      cmd(C_STOP, '0);

      // STOP on the terminal tick of a one-shot at 15.
      cmd(C_LOAD, 4'd15);
      cyc();
      cfg_oneshot = 1'b1; cfg_up = 1'b1;
      cmd(C_START, '0);
      saw_done = 1'b0;
      repeat (3) cyc();
      cmd(C_STOP, '0);
      repeat (4) cyc();
      chk("stop_no_done", 32'(saw_done), 32'd0);
      chk("stop_idle",    32'(busy), 32'd0);
      chk("stop_val",     32'(cnt_val), 32'd15);

      // Reset during the LOAD cycle.
      cmd(C_LOAD, 4'd7);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("rst_load_off", 32'(cnt_load), 32'd0);
      chk("rst_idle",     32'(busy), 32'd0);
      repeat (3) cyc();
      chk("rst_val_kept", 32'(cnt_val), 32'd7);

      // Randomized commands, configuration and occasional resets.
      for (int i = 0; i < 1500; i++) begin
         rst = ($urandom_range(0, 79) == 0);
         cif.cmd_valid = ($urandom_range(0, 9) == 0);
         cif.cmd_op    = 2'($urandom_range(0, 3));
         cif.cmd_data  = 4'($urandom_range(0, 15));
         cfg_oneshot   = 1'($urandom_range(0, 1));
         cfg_up        = 1'($urandom_range(0, 1));
         cyc();
      end
      rst = 1'b0; cif.cmd_valid = 1'b0;
      cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
